uart_rx_fifo: RTL and testbench

- Synthesizable UART receiver driven by the simulated UART's serial output; the first RTL stage that consumes the line.
- Oversamples the serial line with the system clock and rejects start-bit glitches.
- Deserializes 8N1 frames LSB first and buffers received bytes in a small FIFO with a ready/valid output.
- Feeds downstream logic (e.g. an echo path or MMIO register) and reports framing and overflow errors.

---
 rtl/uart_rx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, oversampled, start-glitch rejection) feeding a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx_fifo #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_rx,
  output logic       io_data_valid,
  output logic [7:0] io_data_bits,
  input  logic       io_data_ready,
  output logic       io_busy,
  output logic       io_framing_error,
  output logic       io_overflow
);

  localparam int DIV  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [AW:0]   CNT_MAX  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd5;
`endif

  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          ferr_q;
  logic          ovf_q;
`ifdef UART_RX_PARITY_EN
  logic          par_err;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic tick;
  logic push_req;
  logic push_ok;
  logic pop;

  assign tick = (cnt == '0);
`ifdef UART_RX_PARITY_EN
  assign push_req = (state == S_STOP) && tick && rx_s && !par_err;
`else
  assign push_req = (state == S_STOP) && tick && rx_s;
`endif
  assign pop     = io_data_valid && io_data_ready;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push_ok = push_req && ((count != CNT_MAX) || pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      rx_meta <= io_rx;
      rx_s    <= rx_meta;
      ferr_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt   <= CNT_HALF;
            state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (!rx_s) begin
              cnt     <= CNT_FULL;
              bit_idx <= '0;
              state   <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg[bit_idx] <= rx_s;
            cnt            <= CNT_FULL;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            par_err <= (^shreg) ^ rx_s;
            cnt     <= CNT_FULL;
            state   <= S_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (!rx_s) begin
              ferr_q <= 1'b1;
              state  <= S_WAIT_IDLE;
            end else begin
`ifdef UART_RX_PARITY_EN
              ferr_q <= par_err;
`endif
              state  <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= push_req && !push_ok;
      if (push_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign io_data_valid    = (count != '0);
  assign io_data_bits     = io_data_valid ? mem[rd_ptr] : '0;
  assign io_busy          = (state != S_IDLE);
  assign io_framing_error = ferr_q;
  assign io_overflow      = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table of frames plus latency, stream,
// overflow, glitch and mid-frame reset sequences. Honours UART_RX_PARITY_EN.
module tb_uart_rx_fifo;

  localparam int CLK_F = 10_000_000;
  localparam int BAUD  = 460_800;
  localparam int DIV   = CLK_F / BAUD;   // 21 cycles per bit
  localparam int HALF  = DIV / 2;
  localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       io_rx = 1'b1;
  logic       io_data_ready = 1'b0;
  logic       io_data_valid;
  logic [7:0] io_data_bits;
  logic       io_busy;
  logic       io_framing_error;
  logic       io_overflow;

  always #5 clock = ~clock;

  uart_rx_fifo #(
    .CLOCK_FREQUENCY(CLK_F),
    .BAUD_RATE      (BAUD),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .io_rx           (io_rx),
    .io_data_valid   (io_data_valid),
    .io_data_bits    (io_data_bits),
    .io_data_ready   (io_data_ready),
    .io_busy         (io_busy),
    .io_framing_error(io_framing_error),
    .io_overflow     (io_overflow)
  );

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] popped [$];

  always @(negedge clock) begin
    if (io_data_valid && io_data_ready) popped.push_back(io_data_bits);
    if (io_overflow) ovf_cnt++;
    if (io_framing_error) ferr_cnt++;
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive_bit(input logic b, input int cycles);
    io_rx = b;
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int cycles);
    drive_bit(1'b1, cycles);
  endtask

  // stop_ok=0 holds the line low for two bit times in place of the stop bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_ok, input logic par_flip);
    drive_bit(1'b0, DIV);
    for (int i = 0; i < 8; i++) drive_bit(data[i], DIV);
`ifdef UART_RX_PARITY_EN
    drive_bit((^data) ^ par_flip, DIV);
`else
    if (par_flip) io_rx = 1'b1;
`endif
    if (stop_ok) drive_bit(1'b1, DIV);
    else         drive_bit(1'b0, 2 * DIV);
    io_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         exp_push;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, o0, n, bound;
    logic seen;

    vecs[0] = '{8'h00, 1'b1, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 1, 0};
    vecs[2] = '{8'h55, 1'b0, 0, 1};
    vecs[3] = '{8'hAA, 1'b1, 1, 0};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'h01, 1'b1, 1, 0};

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", io_data_valid, 0);
    check("rst_bits", io_data_bits, 0);
    check("rst_busy", io_busy, 0);
    check("rst_ferr", io_framing_error, 0);
    check("rst_ovf", io_overflow, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    idle(4);

    // Single byte with latency bound
    io_data_ready = 1'b1;
    popped.delete();
    f0 = ferr_cnt; o0 = ovf_cnt;
    bound = (19 * DIV) / 2 + 4 + PBITS * DIV;
    seen = 1'b0;
    n = 0;
    fork
      send_frame(8'h41, 1'b1, 1'b0);
      begin
        while (!seen && n < bound + DIV) begin
          @(negedge clock);
          n++;
          if (io_data_valid) seen = 1'b1;
        end
        check("lat_seen", seen, 1);
        check("lat_bits", io_data_bits, 8'h41);
        check("lat_within_bound", (n <= bound) && (n >= 9 * DIV), 1);
        @(negedge clock);
        check("lat_one_cycle", io_data_valid, 0);
      end
    join
    idle(DIV);
    check("single_count", popped.size(), 1);
    check("single_ferr", ferr_cnt - f0, 0);
    check("single_ovf", ovf_cnt - o0, 0);

    // Table-driven frames
    foreach (vecs[k]) begin
      popped.delete();
      f0 = ferr_cnt; o0 = ovf_cnt;
      send_frame(vecs[k].data, vecs[k].stop_ok, 1'b0);
      idle(2 * DIV);
      check($sformatf("vec%0d_pushes", k), popped.size(), vecs[k].exp_push);
      check($sformatf("vec%0d_ferr", k), ferr_cnt - f0, vecs[k].exp_ferr);
      check($sformatf("vec%0d_ovf", k), ovf_cnt - o0, 0);
      check($sformatf("vec%0d_busy", k), io_busy, 0);
      for (int j = 0; j < popped.size(); j++)
        check($sformatf("vec%0d_byte", k), popped[j], vecs[k].data);
    end

    // Back-to-back stream
    popped.delete();
    o0 = ovf_cnt; f0 = ferr_cnt;
    for (int i = 0; i < 8; i++) send_frame(8'h41 + 8'(i), 1'b1, 1'b0);
    idle(2 * DIV);
    check("stream_count", popped.size(), 8);
    for (int i = 0; i < popped.size(); i++)
      check($sformatf("stream_byte%0d", i), popped[i], 8'h41 + i);
    check("stream_ovf", ovf_cnt - o0, 0);
    check("stream_ferr", ferr_cnt - f0, 0);

    // Overflow
    io_data_ready = 1'b0;
    popped.delete();
    o0 = ovf_cnt;
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    idle(DIV);
    check("ovf_none_at_full", ovf_cnt - o0, 0);
    send_frame(8'h18, 1'b1, 1'b0);
    idle(DIV);
    check("ovf_pulse", ovf_cnt - o0, 1);
    @(negedge clock);
    check("ovf_head_valid", io_data_valid, 1);
    check("ovf_head_bits", io_data_bits, 8'h10);
    @(posedge clock); #1;
    io_data_ready = 1'b1;
    idle(DEPTH + 4);
    check("ovf_drain_count", popped.size(), 8);
    for (int i = 0; i < popped.size(); i++)
      check($sformatf("ovf_drain%0d", i), popped[i], 8'h10 + i);
    @(negedge clock);
    check("ovf_drain_empty", io_data_valid, 0);
    @(posedge clock); #1;

    // Start-bit glitch
    popped.delete();
    f0 = ferr_cnt;
    drive_bit(1'b0, 4);
    io_rx = 1'b1;
    @(negedge clock);
    check("glitch_busy_high", io_busy, 1);
    repeat (HALF + 4) @(negedge clock);
    check("glitch_busy_low", io_busy, 0);
    @(posedge clock); #1;
    idle(DIV);
    check("glitch_push", popped.size(), 0);
    check("glitch_ferr", ferr_cnt - f0, 0);

    // Reset mid-frame with a byte already buffered
    io_data_ready = 1'b0;
    popped.delete();
    send_frame(8'h77, 1'b1, 1'b0);
    idle(DIV);
    @(negedge clock);
    check("prerst_valid", io_data_valid, 1);
    check("prerst_bits", io_data_bits, 8'h77);
    @(posedge clock); #1;
    f0 = ferr_cnt; o0 = ovf_cnt;
    drive_bit(1'b0, DIV);
    for (int i = 0; i < 4; i++) drive_bit(((8'h3C >> i) & 8'h01) != 0, DIV);
    drive_bit(1'b1, HALF);
    @(negedge clock);
    check("midrst_busy_before", io_busy, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("midrst_valid", io_data_valid, 0);
    check("midrst_bits", io_data_bits, 0);
    check("midrst_busy", io_busy, 0);
    check("midrst_ferr", io_framing_error, 0);
    check("midrst_ovf", io_overflow, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    idle(12 * DIV);
    @(negedge clock);
    check("postrst_empty", io_data_valid, 0);
    check("postrst_ferr", ferr_cnt - f0, 0);
    check("postrst_ovf", ovf_cnt - o0, 0);
    @(posedge clock); #1;
    io_data_ready = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(2 * DIV);
    check("postrst_count", popped.size(), 1);
    for (int i = 0; i < popped.size(); i++) check("postrst_byte", popped[i], 8'h3C);

`ifdef UART_RX_PARITY_EN
    popped.delete();
    f0 = ferr_cnt;
    send_frame(8'h41, 1'b1, 1'b0);
    idle(2 * DIV);
    check("par_good_count", popped.size(), 1);
    check("par_good_ferr", ferr_cnt - f0, 0);
    popped.delete();
    f0 = ferr_cnt;
    send_frame(8'h41, 1'b1, 1'b1);
    idle(2 * DIV);
    check("par_bad_count", popped.size(), 0);
    check("par_bad_ferr", ferr_cnt - f0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
